// File: rtl/comparador_2b.sv
// Registered equality/magnitude comparator with a saturating mismatch counter.
// Optional macro COMPARADOR_SIGNED_EN switches GT/LT to two's-complement ordering.
module comparador_2b #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             X,
    output logic             GT,
    output logic             LT,
    output logic             out_valid,
    output logic [CNT_W-1:0] mism_cnt
);

    // Flow: in_valid qualifies A/B at a rising edge; the results appear after that
    // edge with out_valid high for exactly one cycle. There is no ready/back-pressure.
    logic             eq_c;
    logic             gt_c;
    logic             lt_c;

    logic             x_q, x_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        eq_c = (A == B);
`ifdef COMPARADOR_SIGNED_EN
        gt_c = ($signed(A) > $signed(B));
        lt_c = ($signed(A) < $signed(B));
`else
        gt_c = (A > B);
        lt_c = (A < B);
`endif
    end

    always_comb begin
        x_d         = x_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        out_valid_d = in_valid;
        cnt_d       = cnt_q;
        if (in_valid) begin
            x_d  = eq_c;
            gt_d = gt_c;
            lt_d = lt_c;
            // Count sticks at all-ones instead of wrapping.
            if (!eq_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            x_q         <= x_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign X         = x_q;
    assign GT        = gt_q;
    assign LT        = lt_q;
    assign out_valid = out_valid_q;
    assign mism_cnt  = cnt_q;

endmodule

// File: tb/tb_comparador_2b.sv
// Directed bench for comparador_2b (WIDTH=2, CNT_W=8); honours COMPARADOR_SIGNED_EN.
module tb_comparador_2b;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] A;
    logic [1:0] B;
    logic       X;
    logic       GT;
    logic       LT;
    logic       out_valid;
    logic [7:0] mism_cnt;

    int checks   = 0;
    int failures = 0;

    comparador_2b #(.WIDTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .X         (X),
        .GT        (GT),
        .LT        (LT),
        .out_valid (out_valid),
        .mism_cnt  (mism_cnt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 2'd0, 2'd0);
        step(1'b1, 1'b0, 2'd0, 2'd0);
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got X/GT/LT/ov=%b required 0000", {X, GT, LT, out_valid});
        end
        checks++;
        if (mism_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d required 0", mism_cnt);
        end
    endtask

    task automatic test_basic();
        step(1'b0, 1'b1, 2'd2, 2'd3);
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0011) begin
            failures++;
            $display("FAIL basic_2v3: got X/GT/LT/ov=%b required 0011", {X, GT, LT, out_valid});
        end
        checks++;
        if (mism_cnt !== 8'd1) begin
            failures++;
            $display("FAIL basic_2v3_cnt: got %0d required 1", mism_cnt);
        end
        step(1'b0, 1'b1, 2'd1, 2'd1);
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b1001) begin
            failures++;
            $display("FAIL basic_1v1: got X/GT/LT/ov=%b required 1001", {X, GT, LT, out_valid});
        end
        checks++;
        if (mism_cnt !== 8'd1) begin
            failures++;
            $display("FAIL basic_1v1_cnt: got %0d required 1", mism_cnt);
        end
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 2'd2, 2'd2);
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b1001) begin
            failures++;
            $display("FAIL hold_2v2: got X/GT/LT/ov=%b required 1001", {X, GT, LT, out_valid});
        end
        step(1'b0, 1'b1, 2'd2, 2'd1);
`ifdef COMPARADOR_SIGNED_EN
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0011) begin
            failures++;
            $display("FAIL hold_2v1_signed: got X/GT/LT/ov=%b required 0011", {X, GT, LT, out_valid});
        end
`else
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0101) begin
            failures++;
            $display("FAIL hold_2v1: got X/GT/LT/ov=%b required 0101", {X, GT, LT, out_valid});
        end
`endif
        checks++;
        if (mism_cnt !== 8'd2) begin
            failures++;
            $display("FAIL hold_2v1_cnt: got %0d required 2", mism_cnt);
        end
        // Inputs change while invalid: results must not follow them.
        step(1'b0, 1'b0, 2'd3, 2'd3);
        step(1'b0, 1'b0, 2'd0, 2'd3);
`ifdef COMPARADOR_SIGNED_EN
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL hold_idle: got X/GT/LT/ov=%b required 0010", {X, GT, LT, out_valid});
        end
`else
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0100) begin
            failures++;
            $display("FAIL hold_idle: got X/GT/LT/ov=%b required 0100", {X, GT, LT, out_valid});
        end
`endif
        checks++;
        if (mism_cnt !== 8'd2) begin
            failures++;
            $display("FAIL hold_idle_cnt: got %0d required 2", mism_cnt);
        end
    endtask

    // Counter starts at 2; 253 more mismatches reach 255.
    task automatic test_saturate();
        for (int i = 0; i < 252; i++) step(1'b0, 1'b1, 2'd0, 2'd3);
        checks++;
        if (mism_cnt !== 8'd254) begin
            failures++;
            $display("FAIL sat_254: got %0d required 254", mism_cnt);
        end
        step(1'b0, 1'b1, 2'd0, 2'd3);
        checks++;
        if (mism_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_255: got %0d required 255", mism_cnt);
        end
        for (int i = 0; i < 47; i++) step(1'b0, 1'b1, 2'd0, 2'd3);
        checks++;
        if (mism_cnt !== 8'd255) begin
            failures++;
            $display("FAIL sat_hold: got %0d required 255", mism_cnt);
        end
        checks++;
        if (out_valid !== 1'b1 || X !== 1'b0) begin
            failures++;
            $display("FAIL sat_flags: got ov=%b X=%b required ov=1 X=0", out_valid, X);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b1, 2'd1, 2'd1);
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL rstprio_flags: got X/GT/LT/ov=%b required 0000", {X, GT, LT, out_valid});
        end
        checks++;
        if (mism_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rstprio_cnt: got %0d required 0", mism_cnt);
        end
        step(1'b0, 1'b0, 2'd1, 2'd1);
        checks++;
        if ({X, GT, LT, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL rstprio_after: got X/GT/LT/ov=%b required 0000", {X, GT, LT, out_valid});
        end
    endtask

    // Back-to-back ordering vectors where signed and unsigned answers differ.
    task automatic test_ordering();
        logic [1:0] va [4];
        logic [1:0] vb [4];
        logic [2:0] exp_u [4];
        logic [2:0] exp_s [4];
        logic [2:0] exp_f;
        va[0] = 2'd3; vb[0] = 2'd0; exp_u[0] = 3'b010; exp_s[0] = 3'b001;
        va[1] = 2'd1; vb[1] = 2'd2; exp_u[1] = 3'b001; exp_s[1] = 3'b010;
        va[2] = 2'd3; vb[2] = 2'd3; exp_u[2] = 3'b100; exp_s[2] = 3'b100;
        va[3] = 2'd0; vb[3] = 2'd1; exp_u[3] = 3'b001; exp_s[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, va[i], vb[i]);
`ifdef COMPARADOR_SIGNED_EN
            exp_f = exp_s[i];
`else
            exp_f = exp_u[i];
`endif
            checks++;
            if ({X, GT, LT} !== exp_f || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL order_%0d: got X/GT/LT=%b ov=%b required %b ov=1", i, {X, GT, LT}, out_valid, exp_f);
            end
        end
        checks++;
        if (mism_cnt !== 8'd3) begin
            failures++;
            $display("FAIL order_cnt: got %0d required 3", mism_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = 2'd0; B = 2'd0;
        test_reset();
        test_basic();
        test_hold();
        test_saturate();
        test_reset_priority();
        test_ordering();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
